// File: rtl/weight_encoder_pkg.sv
// weight_pkg: shared states, fixed-point constants and sign helpers for weight_encoder
package weight_pkg;
  localparam int W = 32;
  localparam logic [W-1:0] WEIGHT_SCALE = 32'hFFFFFFFE;
  localparam logic [W-1:0] WEIGHT_MAX = 32'h7FFFFFFF;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic logic [W-1:0] neg_if(input logic s, input logic [W-1:0] v);
    return s ? ~v + 1'b1 : v;
  endfunction
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
    return neg_if(v[W-1], v);
  endfunction
endpackage

// File: rtl/div_step_restoring.sv
// div_step_restoring: one combinational restoring-division step
module div_step_restoring #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);
  logic [WIDTH+1:0] shifted;
  always_comb begin
    shifted = {rem, bit_in};
    q_bit = shifted >= (WIDTH+2)'(divisor);
    rem_next = (WIDTH+1)'(q_bit ? shifted - (WIDTH+2)'(divisor) : shifted);
  end
endmodule

// File: rtl/weight_encoder.sv
// weight_encoder: bit-serial ratio encoder producing signed weight c = num/den * 0xFFFFFFFE
module weight_encoder
  import weight_pkg::*;
#(
  parameter int WIDTH = W,
  parameter logic [WIDTH-1:0] SCALE = WEIGHT_SCALE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] constant,
  output logic             saturated,
  output logic             div_zero
);
  localparam int CW = $clog2(2*WIDTH);
  state_t state, state_n;
  logic [CW-1:0] count;
  // dividend bits shift out of the top while quotient bits shift in at the bottom
  logic [2*WIDTH-1:0] work, quot;
  logic [WIDTH:0] rem, rem_n;
  logic [WIDTH-1:0] den_mag, mag;
  logic sign, num_sign, num_zero, zero, q_bit, sat;
  div_step_restoring #(.WIDTH(WIDTH)) u_step (
    .rem(rem),
    .divisor(den_mag),
    .bit_in(work[2*WIDTH-1]),
    .rem_next(rem_n),
    .q_bit(q_bit)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_n = state;
    quot = {work[2*WIDTH-2:0], q_bit};
    sat = |quot[2*WIDTH-1:WIDTH-1];
    mag = sat ? WEIGHT_MAX : quot[WIDTH-1:0];
    case (state)
      IDLE: state_n = in_valid ? CALC : IDLE;
      CALC: state_n = count == '0 ? DONE : CALC;
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      work <= '0;
      rem <= '0;
      den_mag <= '0;
      sign <= 1'b0;
      num_sign <= 1'b0;
      num_zero <= 1'b0;
      zero <= 1'b0;
      constant <= '0;
      saturated <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        count <= CW'(2*WIDTH-1);
        work <= (2*WIDTH)'(abs_val(numerator)) * (2*WIDTH)'(SCALE);
        rem <= '0;
        den_mag <= abs_val(denominator);
        sign <= numerator[WIDTH-1] ^ denominator[WIDTH-1];
        num_sign <= numerator[WIDTH-1];
        num_zero <= numerator == '0;
        zero <= denominator == '0;
      end
      if (state == CALC) begin
        work <= quot;
        rem <= rem_n;
        count <= count == '0 ? '0 : count - 1'b1;
        if (count == '0) begin
          div_zero <= zero;
          saturated <= zero ? !num_zero : sat;
          constant <= zero ? (num_zero ? '0 : neg_if(num_sign, WEIGHT_MAX)) : neg_if(sign, mag);
        end
      end
    end
  end
endmodule
